calc_ctrl_gen2: RTL
===================

CALC_CTRL_GEN2 -- requirements
Module: calc_ctrl_gen2

Parameters
REQ-001 SHALL have parameter MAX_DIGITS, default 8, meaning the maximum digits accepted per operand (1..15).
REQ-002 SHALL have parameter NUM_OPS, default 3, meaning the number of operation keys decoded (1..4).

Interface
REQ-003 SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port key, input, 4 bits: key code, 0-9 digit, 10..9+NUM_OPS operation, 14 backspace, 15 clear.
REQ-006 SHALL have port key_valid, input, 1 bit: key is valid this cycle; one pulse per press.
REQ-007 SHALL have port full_acc, input, 1 bit: ALU accumulator overflow.
REQ-008 SHALL have port full_aux, input, 1 bit: ALU operand register full.
REQ-009 SHALL have port busy_disp, input, 1 bit: display refresh in progress.
REQ-010 SHALL have port digit, output, 4 bits: digit code to the ALU; 4'hE means backspace.
REQ-011 SHALL have port digit_valid, output, 1 bit: one-cycle digit strobe.
REQ-012 SHALL have port operation, output, 3 bits: operation code, key minus 9.
REQ-013 SHALL have port op_valid, output, 1 bit: one-cycle operation strobe.
REQ-014 SHALL have port clear_alu, output, 1 bit: one-cycle ALU clear.
REQ-015 SHALL have port update_disp, output, 1 bit: one-cycle display refresh request.
REQ-016 SHALL have port error, output, 1 bit: level, high while in ERROR.
REQ-017 SHALL have port digit_count, output, 4 bits: digits in the current operand.

Function
REQ-018 States SHALL be CLEAR, IDLE, DIGIT, OP, ISSUE, DISP_WAIT, ERROR.
REQ-019 Key 15 with key_valid SHALL force CLEAR next cycle from any state (highest priority).
REQ-020 Other keys SHALL be sampled only in IDLE and captured into a locked register; in other states they are dropped.
REQ-021 Key codes 10+NUM_OPS..13, and 14 when backspace is disabled, SHALL be ignored, staying in IDLE.
REQ-022 CLEAR SHALL pulse clear_alu, zero digit_count, and go to ISSUE.
REQ-023 DIGIT with digit_count==0 and key 0 SHALL drop the key and return to IDLE (leading-zero suppression).
REQ-024 DIGIT with digit_count==MAX_DIGITS, or with full_aux or full_acc high, SHALL drop the key and return to IDLE.
REQ-025 Otherwise DIGIT SHALL drive digit and pulse digit_valid, increment digit_count, and go to ISSUE.
REQ-026 OP with full_acc low SHALL drive operation, pulse op_valid, zero digit_count, and go to ISSUE.
REQ-027 OP with full_acc high SHALL return to IDLE.
REQ-028 ISSUE SHALL pulse update_disp and go to DISP_WAIT.
REQ-029 DISP_WAIT SHALL ignore busy_disp in its first cycle, then wait while busy_disp is high.
REQ-030 On leaving DISP_WAIT, SHALL go to ERROR if full_acc is high, else to IDLE.
REQ-031 Latency for an accepted digit: key at cycle N, digit_valid at N+1, update_disp at N+2.
REQ-032 ERROR SHALL hold until key 15; all other keys are ignored.
REQ-033 digit and operation SHALL hold their last values between strobes.
REQ-034 At most one of digit_valid, op_valid, and clear_alu SHALL be high in any cycle.

Reset
REQ-035 rst_n low SHALL asynchronously zero all outputs, digit_count, and the locked key, with state CLEAR.
REQ-036 The first clock after rst_n is released SHALL execute CLEAR (clear_alu pulse).
REQ-037 Reset asserted mid-sequence SHALL abort it with no further strobes.

Configuration
REQ-038 With macro CALC_CTRL_BACKSPACE_EN defined, key 14 in IDLE with digit_count>0 SHALL drive digit=4'hE, pulse digit_valid, decrement digit_count, and go to ISSUE.
REQ-039 With CALC_CTRL_BACKSPACE_EN defined, key 14 with digit_count==0 SHALL be ignored.
REQ-040 Without CALC_CTRL_BACKSPACE_EN, key 14 SHALL always be ignored and no 4'hE digit is ever emitted.

Verification
REQ-041 Release rst_n, busy_disp=0 -> clear_alu at cycle 1, update_disp at cycle 2, IDLE by cycle 4, digit_count=0.
REQ-042 Keys 0,4,2 -> key 0 dropped, digits 4 then 2 strobed, digit_count=2.
REQ-043 MAX_DIGITS=3, keys 1,2,3,4 -> fourth key dropped, digit_count=3.
REQ-044 Key 11 with busy_disp high 5 cycles after update_disp -> operation=2, op_valid once, IDLE 1 cycle after busy_disp falls.
REQ-045 full_acc=1 at end of DISP_WAIT -> error=1, key 5 ignored, key 15 -> clear_alu and error=0.
REQ-046 Backspace enabled, keys 7,8,14 -> digit=4'hE strobed, digit_count=1; macro undefined -> key 14 ignored.

Source files
------------

// File: rtl/calc_ctrl_gen2_if.sv
// Keypad/ALU/display handshake bundle for calc_ctrl_gen2.
// master: keypad and ALU side, which drives the inputs. slave: the controller.
interface calc_ctrl_gen2_if;
    logic [3:0] key;
    logic       key_valid;
    logic       full_acc;
    logic       full_aux;
    logic       busy_disp;
    logic [3:0] digit;
    logic       digit_valid;
    logic [2:0] operation;
    logic       op_valid;
    logic       clear_alu;
    logic       update_disp;
    logic       error;
    logic [3:0] digit_count;

    modport master (
        output key, key_valid, full_acc, full_aux, busy_disp,
        input  digit, digit_valid, operation, op_valid, clear_alu, update_disp, error,
               digit_count
    );

    modport slave (
        input  key, key_valid, full_acc, full_aux, busy_disp,
        output digit, digit_valid, operation, op_valid, clear_alu, update_disp, error,
               digit_count
    );
endinterface

// File: rtl/calc_ctrl_gen2.sv
// Calculator keypad controller: keys become ALU digit/op strobes and display refresh requests.
// Optional backspace (key 14) is enabled by defining CALC_CTRL_BACKSPACE_EN.
module calc_ctrl_gen2 #(
    parameter int unsigned MAX_DIGITS = 8,
    parameter int unsigned NUM_OPS    = 3
) (
    input logic             clk,
    input logic             rst_n,
    calc_ctrl_gen2_if.slave bus
);

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StDigit,
        StOp,
        StIssue,
        StDispWait,
        StError
    } state_e;

    localparam logic [3:0] MaxCount  = 4'(MAX_DIGITS);
    localparam logic [3:0] LastOpKey = 4'(9 + NUM_OPS);
    localparam logic [3:0] KeyClear  = 4'd15;
`ifdef CALC_CTRL_BACKSPACE_EN
    localparam logic [3:0] KeyBack   = 4'd14;
`endif

    state_e     state_q;
    logic [3:0] locked_key_q;
    logic [3:0] digit_q;
    logic [2:0] operation_q;
    logic [3:0] digit_count_q;
    logic       digit_valid_q;
    logic       op_valid_q;
    logic       clear_alu_q;
    logic       update_disp_q;
    logic       error_q;
    logic       dw_first_q;

    logic is_clear_key;
    logic is_digit_key;
    logic is_op_key;
    logic is_back_key;
    logic digit_ok;

    assign is_clear_key = bus.key_valid && (bus.key == KeyClear);
    assign is_digit_key = bus.key <= 4'd9;
    assign is_op_key    = (bus.key >= 4'd10) && (bus.key <= LastOpKey);
`ifdef CALC_CTRL_BACKSPACE_EN
    assign is_back_key  = (bus.key == KeyBack) && (digit_count_q != 4'd0);
`else
    assign is_back_key  = 1'b0;
`endif

    // Leading zero, a full operand, or a full ALU all drop the digit.
    assign digit_ok = !((digit_count_q == 4'd0) && (locked_key_q == 4'd0)) &&
                      (digit_count_q < MaxCount) && !bus.full_aux && !bus.full_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StClear;
            locked_key_q  <= 4'd0;
            digit_q       <= 4'd0;
            operation_q   <= 3'd0;
            digit_count_q <= 4'd0;
            digit_valid_q <= 1'b0;
            op_valid_q    <= 1'b0;
            clear_alu_q   <= 1'b0;
            update_disp_q <= 1'b0;
            error_q       <= 1'b0;
            dw_first_q    <= 1'b0;
        end else begin
            digit_valid_q <= 1'b0;
            op_valid_q    <= 1'b0;
            clear_alu_q   <= 1'b0;
            update_disp_q <= 1'b0;

            if (is_clear_key) begin
                state_q <= StClear;
                error_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StClear: begin
                        clear_alu_q   <= 1'b1;
                        digit_count_q <= 4'd0;
                        state_q       <= StIssue;
                    end
                    StIdle: begin
                        if (bus.key_valid) begin
                            if (is_digit_key || is_back_key) begin
                                locked_key_q <= bus.key;
                                state_q      <= StDigit;
                            end else if (is_op_key) begin
                                locked_key_q <= bus.key;
                                state_q      <= StOp;
                            end
                        end
                    end
                    StDigit: begin
                        state_q <= StIdle;
`ifdef CALC_CTRL_BACKSPACE_EN
                        // Backspace was qualified on a non-zero count when it was locked.
                        if (locked_key_q == KeyBack) begin
                            digit_q       <= 4'hE;
                            digit_valid_q <= 1'b1;
                            digit_count_q <= digit_count_q - 4'd1;
                            state_q       <= StIssue;
                        end else
`endif
                        if (digit_ok) begin
                            digit_q       <= locked_key_q;
                            digit_valid_q <= 1'b1;
                            digit_count_q <= digit_count_q + 4'd1;
                            state_q       <= StIssue;
                        end
                    end
                    StOp: begin
                        if (!bus.full_acc) begin
                            operation_q   <= 3'(locked_key_q - 4'd9);
                            op_valid_q    <= 1'b1;
                            digit_count_q <= 4'd0;
                            state_q       <= StIssue;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    StIssue: begin
                        update_disp_q <= 1'b1;
                        dw_first_q    <= 1'b1;
                        state_q       <= StDispWait;
                    end
                    StDispWait: begin
                        // busy_disp may not yet reflect the request on the first cycle.
                        if (dw_first_q) begin
                            dw_first_q <= 1'b0;
                        end else if (!bus.busy_disp) begin
                            if (bus.full_acc) begin
                                error_q <= 1'b1;
                                state_q <= StError;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StError: begin
                        state_q <= StError;
                    end
                    default: begin
                        state_q <= StClear;
                    end
                endcase
            end
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.operation   = operation_q;
    assign bus.op_valid    = op_valid_q;
    assign bus.clear_alu   = clear_alu_q;
    assign bus.update_disp = update_disp_q;
    assign bus.error       = error_q;
    assign bus.digit_count = digit_count_q;

    assert property (@(posedge clk) disable iff (!rst_n)
                     $onehot0({digit_valid_q, op_valid_q, clear_alu_q}));

endmodule
